spi_flash_responder: RTL and testbench

Synthesizable SPI flash target emulator: the responder end of the SPI read protocol issued by the SPI flash wrapper. It decodes mode-0 SPI frames (READ 0x03, JEDEC ID 0x9F) from an external or on-chip SPI initiator and returns bytes fetched from a synchronous backing memory. It sits between the SPI pins and a BRAM/ROM image, and serves as both the loopback target for SoC bring-up and the flash stand-in for the wrapper's benches. All SPI inputs are oversampled in the `clk_i` domain.

---
 rtl/spi_flash_responder.sv | 197 +++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder.sv
// rtl/spi_flash_responder.sv - SPI mode-0 flash responder serving READ/JEDEC ID from a synchronous byte memory
// Optional feature macro: SPI_RESP_FAST_READ_EN (FAST READ 0x0B with 8 dummy clocks).
// Ports:
//   clk_i, rstn_i                     system clock, synchronous active-low reset
//   spi_sck_i, spi_csn_i, spi_mosi_i  asynchronous SPI pins, oversampled in clk_i
//   spi_miso_o, spi_miso_oe_o         responder data and its output enable
//   mem_rd_o, mem_addr_o              one-cycle read strobe and read address
//   mem_rdata_i                       read data, valid one cycle after mem_rd_o
//   busy_o                            high while a frame is being handled
module spi_flash_responder #(
  parameter int unsigned ADDR_W   = 24,
  parameter logic [23:0] JEDEC_ID = 24'hEF4018
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              spi_sck_i,
  input  logic              spi_csn_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_oe_o,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              busy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_ID, S_IGNORE
  } state_t;

  state_t state_q, state_n;

  logic [2:0]        sck_sync_q, csn_sync_q;
  logic [1:0]        mosi_sync_q;
  logic              sck_rise, sck_fall, csn_low, csn_fall, mosi_s;
  logic [4:0]        bit_cnt_q;
  logic [22:0]       in_sr_q;
  logic [23:0]       in_next;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        sr_q, staged_q, next_byte, id_next_byte;
  logic              rd_q, rd_pend_q, started_q, fast_q, miso_q;
  logic [1:0]        id_idx_q, id_idx_next;
  logic              byte_done, addr_done, cmd_fast;

  assign sck_rise  = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall  = ~sck_sync_q[1] & sck_sync_q[2];
  assign csn_low   = ~csn_sync_q[1];
  assign csn_fall  = ~csn_sync_q[1] & csn_sync_q[2];
  assign mosi_s    = mosi_sync_q[1];
  assign in_next   = {in_sr_q, mosi_s};
  assign byte_done = sck_rise && (bit_cnt_q == 5'd7);
  assign addr_done = sck_rise && (bit_cnt_q == 5'd23);

  assign id_idx_next = (id_idx_q == 2'd2) ? 2'd0 : id_idx_q + 2'd1;

  always_comb begin
    case (id_idx_next)
      2'd0:    id_next_byte = JEDEC_ID[23:16];
      2'd1:    id_next_byte = JEDEC_ID[15:8];
      default: id_next_byte = JEDEC_ID[7:0];
    endcase
  end

  assign next_byte = (state_q == S_ID) ? id_next_byte : staged_q;

  always_comb begin
    state_n  = state_q;
    cmd_fast = 1'b0;
    if (state_q != S_IDLE && !csn_low) begin
      state_n = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (csn_fall) state_n = S_CMD;
        S_CMD: begin
          if (byte_done) begin
            case (in_next[7:0])
              8'h03: state_n = S_ADDR;
              8'h9F: state_n = S_ID;
`ifdef SPI_RESP_FAST_READ_EN
              8'h0B: begin
                state_n  = S_ADDR;
                cmd_fast = 1'b1;
              end
`endif
              default: state_n = S_IGNORE;
            endcase
          end
        end
        S_ADDR:  if (addr_done) state_n = fast_q ? S_DUMMY : S_DATA;
        S_DUMMY: if (byte_done) state_n = S_DATA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      // CSn synchronizer resets to "low" so a frame already in progress
      // cannot produce a falling edge; only a fresh high-then-low starts one.
      sck_sync_q  <= '0;
      csn_sync_q  <= '0;
      mosi_sync_q <= '0;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      in_sr_q     <= '0;
      addr_q      <= '0;
      sr_q        <= '0;
      staged_q    <= '0;
      rd_q        <= 1'b0;
      rd_pend_q   <= 1'b0;
      started_q   <= 1'b0;
      fast_q      <= 1'b0;
      miso_q      <= 1'b0;
      id_idx_q    <= '0;
    end else begin
      sck_sync_q  <= {sck_sync_q[1:0], spi_sck_i};
      csn_sync_q  <= {csn_sync_q[1:0], spi_csn_i};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi_i};
      state_q     <= state_n;
      rd_q        <= 1'b0;
      rd_pend_q   <= rd_q;
      // First byte of a read goes straight to the shifter; prefetches are
      // staged until the current byte has been fully shifted out.
      if (rd_pend_q) begin
        if (started_q) staged_q <= mem_rdata_i;
        else           sr_q     <= mem_rdata_i;
      end
      if (state_n == S_IDLE) begin
        bit_cnt_q <= '0;
        started_q <= 1'b0;
        rd_pend_q <= 1'b0;
        miso_q    <= 1'b0;
        fast_q    <= 1'b0;
        id_idx_q  <= '0;
      end else begin
        case (state_q)
          S_CMD: begin
            if (sck_rise) begin
              in_sr_q   <= in_next[22:0];
              bit_cnt_q <= byte_done ? 5'd0 : bit_cnt_q + 5'd1;
              fast_q    <= cmd_fast;
              if (state_n == S_ID) begin
                sr_q     <= JEDEC_ID[23:16];
                id_idx_q <= '0;
              end
            end
          end
          S_ADDR: begin
            if (sck_rise) begin
              in_sr_q   <= in_next[22:0];
              bit_cnt_q <= addr_done ? 5'd0 : bit_cnt_q + 5'd1;
              if (addr_done) begin
                addr_q <= in_next[ADDR_W-1:0];
                rd_q   <= 1'b1;
              end
            end
          end
          S_DUMMY: begin
            if (sck_rise) bit_cnt_q <= byte_done ? 5'd0 : bit_cnt_q + 5'd1;
          end
          S_DATA, S_ID: begin
            // bit_cnt_q counts bits already presented within the current byte.
            if (sck_fall) begin
              if (!started_q) begin
                miso_q    <= sr_q[7];
                started_q <= 1'b1;
                bit_cnt_q <= '0;
              end else if (bit_cnt_q == 5'd7) begin
                sr_q      <= next_byte;
                miso_q    <= next_byte[7];
                bit_cnt_q <= '0;
                if (state_q == S_ID) id_idx_q <= id_idx_next;
              end else begin
                sr_q      <= {sr_q[6:0], 1'b0};
                miso_q    <= sr_q[6];
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
            // Prefetch while the initiator samples bit 7 of the current byte.
            if (state_q == S_DATA && sck_rise && started_q && bit_cnt_q == 5'd0) begin
              addr_q <= addr_q + ADDR_W'(1);
              rd_q   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign spi_miso_o    = miso_q;
  assign spi_miso_oe_o = (state_q == S_DATA) || (state_q == S_ID);
  assign mem_rd_o      = rd_q;
  assign mem_addr_o    = addr_q;
  assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_flash_responder.sv
// tb/tb_spi_flash_responder.sv - directed/randomized bench for spi_flash_responder against a byte-level reference
module tb_spi_flash_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn = 1'b0, sck = 1'b0, csn = 1'b1, mosi = 1'b0;
  logic miso, oe, mem_rd, busy;
  logic [23:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic miso8, oe8, mem_rd8, busy8;
  logic [7:0]  mem_addr8;
  logic [7:0]  mem_rdata8;

  spi_flash_responder dut (
    .clk_i(clk), .rstn_i(rstn), .spi_sck_i(sck), .spi_csn_i(csn), .spi_mosi_i(mosi),
    .spi_miso_o(miso), .spi_miso_oe_o(oe), .mem_rd_o(mem_rd), .mem_addr_o(mem_addr),
    .mem_rdata_i(mem_rdata), .busy_o(busy)
  );

  spi_flash_responder #(.ADDR_W(8)) dut8 (
    .clk_i(clk), .rstn_i(rstn), .spi_sck_i(sck), .spi_csn_i(csn), .spi_mosi_i(mosi),
    .spi_miso_o(miso8), .spi_miso_oe_o(oe8), .mem_rd_o(mem_rd8), .mem_addr_o(mem_addr8),
    .mem_rdata_i(mem_rdata8), .busy_o(busy8)
  );

  logic [7:0]  mem [256];
  int          total = 0, bad = 0;
  int          rd_cnt = 0, rd_cnt8 = 0, rd_double = 0;
  logic        rd_prev = 1'b0;
  logic [23:0] rd_addrs [$];
  logic [7:0]  rd_addrs8 [$];

  // Backing memories: data only valid the cycle after a strobe, noise otherwise.
  always @(posedge clk) begin
    mem_rdata  <= mem_rd  ? mem[mem_addr[7:0]] : 8'($urandom);
    mem_rdata8 <= mem_rd8 ? mem[mem_addr8]      : 8'($urandom);
    if (mem_rd)  rd_addrs.push_back(mem_addr);
    if (mem_rd8) rd_addrs8.push_back(mem_addr8);
    if (mem_rd)  rd_cnt  <= rd_cnt + 1;
    if (mem_rd8) rd_cnt8 <= rd_cnt8 + 1;
    if (mem_rd && rd_prev) rd_double <= rd_double + 1;
    rd_prev <= mem_rd;
  end

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] rx, rx8, dummy_rx;
  logic       oe_any, oe_all, hdr_oe, data_oe_all, busy_mid;
  logic [7:0] got [16];
  logic [7:0] got8 [16];
  logic [23:0] jed = 24'hEF4018;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic half();
    repeat (5) @(negedge clk);
  endtask

  task automatic xfer_n(input logic [7:0] tx, input int n);
    oe_any = 1'b0; oe_all = 1'b1; rx = '0; rx8 = '0;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = tx[i];
      half();
      rx[i] = miso; rx8[i] = miso8;
      oe_any |= oe; oe_all &= oe;
      sck = 1'b1;
      half();
      sck = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] tx);
    xfer_n(tx, 8);
  endtask

  task automatic cs_low();
    csn = 1'b0;
    half();
  endtask

  task automatic cs_high();
    half();
    csn = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic do_read(input logic [7:0] cmd, input logic [23:0] a, input int n, input bit with_dummy);
    hdr_oe = 1'b0; data_oe_all = 1'b1; dummy_rx = '0;
    rd_addrs.delete(); rd_addrs8.delete();
    cs_low();
    xfer(cmd);       hdr_oe |= oe_any;
    xfer(a[23:16]);  hdr_oe |= oe_any;
    xfer(a[15:8]);   hdr_oe |= oe_any;
    xfer(a[7:0]);    hdr_oe |= oe_any;
    if (with_dummy) begin
      xfer(8'($urandom)); hdr_oe |= oe_any; dummy_rx = rx;
    end
    for (int k = 0; k < n; k++) begin
      xfer(8'($urandom));
      got[k] = rx; got8[k] = rx8;
      data_oe_all &= oe_all;
    end
    busy_mid = busy;
    cs_high();
  endtask

  initial begin
    int base, base8, n;
    logic [23:0] a;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    repeat (4) @(negedge clk);
    chk("reset_miso", miso, 0);
    chk("reset_oe", oe, 0);
    chk("reset_mem_rd", mem_rd, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_busy", busy, 0);
    rstn = 1'b1;
    repeat (12) @(negedge clk);

    // Plain READ of 4 bytes at 0x000010
    base = rd_cnt;
    do_read(8'h03, 24'h000010, 4, 1'b0);
    for (int k = 0; k < 4; k++) chk($sformatf("read10_byte%0d", k), got[k], 8'h10 + 8'(k));
    chk("read10_rd_count_range", (rd_cnt - base >= 4) && (rd_cnt - base <= 5), 1);
    chk("read10_first_addr", rd_addrs.size() > 0 ? rd_addrs[0] : 24'hxxxxxx, 24'h000010);
    chk("read10_hdr_oe", hdr_oe, 0);
    chk("read10_data_oe", data_oe_all, 1);
    chk("read10_busy_mid", busy_mid, 1);
    chk("read10_busy_after", busy, 0);
    chk("read10_oe_after", oe, 0);
    chk("read10_miso_after", miso, 0);

    // JEDEC ID, 4 bytes wraps back to the first ID byte
    base = rd_cnt; base8 = rd_cnt8;
    cs_low();
    xfer(8'h9F);
    for (int k = 0; k < 4; k++) begin
      xfer(8'($urandom));
      chk($sformatf("jedec_byte%0d", k), rx, 8'(jed >> (8 * (2 - (k % 3)))));
      chk($sformatf("jedec8_byte%0d", k), rx8, 8'(jed >> (8 * (2 - (k % 3)))));
      chk($sformatf("jedec_oe%0d", k), oe_all, 1);
    end
    cs_high();
    chk("jedec_no_reads", rd_cnt - base, 0);
    chk("jedec8_no_reads", rd_cnt8 - base8, 0);

    // Address wrap: 8-bit instance at 0xFF, 24-bit instance at 0xFFFFFF
    do_read(8'h03, 24'h0000FF, 2, 1'b0);
    chk("wrap8_byte0", got8[0], 8'hFF);
    chk("wrap8_byte1", got8[1], 8'h00);
    chk("wrap8_addr1", rd_addrs8.size() > 1 ? rd_addrs8[1] : 8'hxx, 8'h00);
    do_read(8'h03, 24'hFFFFFF, 2, 1'b0);
    chk("wrap24_addr0", rd_addrs.size() > 0 ? rd_addrs[0] : 24'hxxxxxx, 24'hFFFFFF);
    chk("wrap24_addr1", rd_addrs.size() > 1 ? rd_addrs[1] : 24'hxxxxxx, 24'h000000);
    chk("wrap24_byte1", got[1], 8'h00);

    // Frame aborted after 12 address bits: no read, next frame unaffected
    base = rd_cnt; base8 = rd_cnt8;
    cs_low();
    xfer(8'h03);
    xfer(8'h00);
    xfer_n(8'h00, 4);
    cs_high();
    chk("abort_no_reads", rd_cnt - base, 0);
    chk("abort8_no_reads", rd_cnt8 - base8, 0);
    do_read(8'h03, 24'h000020, 1, 1'b0);
    chk("after_abort_byte0", got[0], 8'h20);

    // Unknown command: ignored
    base = rd_cnt;
    cs_low();
    xfer(8'h05);
    for (int k = 0; k < 2; k++) begin
      xfer(8'($urandom));
      chk($sformatf("ignore_oe%0d", k), oe_any, 0);
      chk($sformatf("ignore_miso%0d", k), rx, 0);
    end
    cs_high();
    chk("ignore_no_reads", rd_cnt - base, 0);

`ifdef SPI_RESP_FAST_READ_EN
    do_read(8'h0B, 24'h000030, 2, 1'b1);
    chk("fast_byte0", got[0], 8'h30);
    chk("fast_byte1", got[1], 8'h31);
    chk("fast_dummy_miso", dummy_rx, 0);
    chk("fast_hdr_oe", hdr_oe, 0);
`else
    base = rd_cnt;
    cs_low();
    xfer(8'h0B);
    for (int k = 0; k < 4; k++) begin
      xfer(8'($urandom));
      chk($sformatf("fast_off_oe%0d", k), oe_any, 0);
    end
    cs_high();
    chk("fast_off_no_reads", rd_cnt - base, 0);
`endif

    // Random memory contents, random reads checked against the byte model
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int f = 0; f < 4; f++) begin
      a = 24'($urandom);
      n = $urandom_range(1, 5);
      do_read(8'h03, a, n, 1'b0);
      for (int k = 0; k < n; k++) begin
        chk($sformatf("rand%0d_byte%0d", f, k), got[k], mem[8'(a + 24'(k))]);
        chk($sformatf("rand%0d_byte8_%0d", f, k), got8[k], mem[8'(a + 24'(k))]);
      end
      chk($sformatf("rand%0d_first_addr", f), rd_addrs.size() > 0 ? rd_addrs[0] : 24'hxxxxxx, a);
    end

    // Reset asserted mid-DATA
    a = 24'($urandom);
    cs_low();
    xfer(8'h03); xfer(a[23:16]); xfer(a[15:8]); xfer(a[7:0]);
    xfer(8'h00);
    chk("prereset_byte0", rx, mem[a[7:0]]);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("midreset_miso", miso, 0);
    chk("midreset_oe", oe, 0);
    chk("midreset_mem_rd", mem_rd, 0);
    chk("midreset_mem_addr", mem_addr, 0);
    chk("midreset_busy", busy, 0);
    rstn = 1'b1;
    base = rd_cnt;
    for (int k = 0; k < 2; k++) begin
      xfer(8'($urandom));
      chk($sformatf("postreset_oe%0d", k), oe_any, 0);
      chk($sformatf("postreset_miso%0d", k), rx, 0);
    end
    chk("postreset_busy", busy, 0);
    cs_high();
    chk("postreset_no_reads", rd_cnt - base, 0);
    do_read(8'h03, 24'h000040, 2, 1'b0);
    chk("recover_byte0", got[0], mem[8'h40]);
    chk("recover_byte1", got[1], mem[8'h41]);

    chk("rd_single_cycle", rd_double, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
